// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Shows a 32-bit hex value with per-digit blanking and decimal points. New
// values are staged in a pending buffer and promoted to the displayed shadow
// copy only at a frame boundary, so a frame never mixes old and new data.
//
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   load         one-cycle strobe capturing value/digit_en/dp_en
//   value        nibble i is shown on digit i
//   digit_en     bit i = 1 lights digit i
//   dp_en        bit i = 1 lights the decimal point of digit i
//   anode        digit select, active-low (one low or all high)
//   cathode      segments {g,f,e,d,c,b,a}, active-low
//   dp           decimal point, active-low
//   frame_done   one-cycle pulse after each frame boundary
module seven_seg_scanner #(
  parameter int unsigned DIGIT_TICKS = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_en,
  output logic [7:0]  anode,
  output logic [6:0]  cathode,
  output logic        dp,
  output logic        frame_done
);

  localparam int unsigned CntW = $clog2(DIGIT_TICKS);
  localparam logic [CntW-1:0] TickMax = CntW'(DIGIT_TICKS - 1);

  logic [CntW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            tick, boundary;

  logic [31:0] shadow_value_q, shadow_value_d;
  logic [7:0]  shadow_en_q, shadow_en_d;
  logic [7:0]  shadow_dp_q, shadow_dp_d;
  logic [31:0] pend_value_q, pend_value_d;
  logic [7:0]  pend_en_q, pend_en_d;
  logic [7:0]  pend_dp_q, pend_dp_d;
  logic        pend_valid_q, pend_valid_d;

  logic [7:0] anode_d;
  logic [6:0] cathode_d;
  logic       dp_d;
  logic       digit_on;
  logic [3:0] nibble;

  function automatic logic [6:0] hex_lut(input logic [3:0] n);
    logic [6:0] seg;
    unique case (n)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  always_comb begin
    tick     = (tick_cnt_q == TickMax);
    boundary = tick && (idx_q == 3'd7);

    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    idx_d      = tick ? idx_q + 3'd1 : idx_q;

    shadow_value_d = shadow_value_q;
    shadow_en_d    = shadow_en_q;
    shadow_dp_d    = shadow_dp_q;
    pend_value_d   = pend_value_q;
    pend_en_d      = pend_en_q;
    pend_dp_d      = pend_dp_q;
    pend_valid_d   = pend_valid_q;

    if (boundary) begin
      // A load landing on the boundary bypasses pending and beats older data.
      if (load) begin
        shadow_value_d = value;
        shadow_en_d    = digit_en;
        shadow_dp_d    = dp_en;
      end else if (pend_valid_q) begin
        shadow_value_d = pend_value_q;
        shadow_en_d    = pend_en_q;
        shadow_dp_d    = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_value_d = value;
      pend_en_d    = digit_en;
      pend_dp_d    = dp_en;
      pend_valid_d = 1'b1;
    end

    digit_on  = shadow_en_q[idx_q];
    nibble    = shadow_value_q[{idx_q, 2'b00} +: 4];
    anode_d   = digit_on ? ~(8'b1 << idx_q) : 8'hFF;
    cathode_d = digit_on ? hex_lut(nibble) : 7'h7F;
    dp_d      = digit_on ? ~shadow_dp_q[idx_q] : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q     <= '0;
      idx_q          <= '0;
      shadow_value_q <= '0;
      shadow_en_q    <= '0;
      shadow_dp_q    <= '0;
      pend_value_q   <= '0;
      pend_en_q      <= '0;
      pend_dp_q      <= '0;
      pend_valid_q   <= 1'b0;
      anode          <= 8'hFF;
      cathode        <= 7'h7F;
      dp             <= 1'b1;
      frame_done     <= 1'b0;
    end else begin
      tick_cnt_q     <= tick_cnt_d;
      idx_q          <= idx_d;
      shadow_value_q <= shadow_value_d;
      shadow_en_q    <= shadow_en_d;
      shadow_dp_q    <= shadow_dp_d;
      pend_value_q   <= pend_value_d;
      pend_en_q      <= pend_en_d;
      pend_dp_q      <= pend_dp_d;
      pend_valid_q   <= pend_valid_d;
      anode          <= anode_d;
      cathode        <= cathode_d;
      dp             <= dp_d;
      frame_done     <= boundary;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with DIGIT_TICKS=4 (32-cycle frames). A cycle-count
// model predicts every output; directed steps pin literal values on top.
module tb_seven_seg_scanner;

  localparam int T = 4;
  localparam int FRAME = 8 * T;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] value;
  logic [7:0]  digit_en;
  logic [7:0]  dp_en;
  logic [7:0]  anode;
  logic [6:0]  cathode;
  logic        dp;
  logic        frame_done;

  seven_seg_scanner #(.DIGIT_TICKS(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .digit_en   (digit_en),
    .dp_en      (dp_en),
    .anode      (anode),
    .cathode    (cathode),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  logic [6:0] seg_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct packed {
    logic [31:0] v;
    logic [7:0]  e;
    logic [7:0]  p;
  } entry_t;

  // Model: position in the frame follows from cycles since reset.
  int     cyc = 0;
  entry_t sh;
  entry_t pend_q[$];
  logic   model_ok = 1'b0;
  logic [7:0] e_an;
  logic [6:0] e_cat;
  logic       e_dp, e_fd;

  always @(posedge clk) begin
    int     midx;
    bit     bnd;
    entry_t in_e;
    in_e = '{v: value, e: digit_en, p: dp_en};
    if (rst) begin
      cyc <= 0;
      sh <= '0;
      pend_q.delete();
      e_an <= 8'hFF;
      e_cat <= 7'h7F;
      e_dp <= 1'b1;
      e_fd <= 1'b0;
      model_ok <= 1'b1;
    end else begin
      midx = (cyc / T) % 8;
      bnd = (cyc % FRAME) == FRAME - 1;
      if (sh.e[midx]) begin
        e_an <= ~(8'h01 << midx);
        e_cat <= seg_tab[(sh.v >> (4 * midx)) & 32'hF];
        e_dp <= ~sh.p[midx];
      end else begin
        e_an <= 8'hFF;
        e_cat <= 7'h7F;
        e_dp <= 1'b1;
      end
      e_fd <= bnd;
      if (bnd) begin
        if (load) sh <= in_e;
        else if (pend_q.size() > 0) sh <= pend_q[$];
        pend_q.delete();
      end else if (load) begin
        pend_q.push_back(in_e);
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("anode", anode, e_an);
      chk("cathode", cathode, e_cat);
      chk("dp", dp, e_dp);
      chk("frame_done", frame_done, e_fd);
      chk("onehot", (anode == 8'hFF || $countones(~anode) == 1), 1);
    end
  end

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge where frame_done is seen high.
  task automatic wait_fd();
    bit got = 1'b0;
    for (int i = 0; i < 3 * FRAME && !got; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) got = 1'b1;
    end
    chk("fd_wait", got, 1);
  endtask

  task automatic pulse_load(input logic [31:0] v, input logic [7:0] e, input logic [7:0] p);
    value = v;
    digit_en = e;
    dp_en = p;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    load = 1'b0;
    value = '0;
    digit_en = '0;
    dp_en = '0;
    skip(3);
    chk("rst_anode", anode, 8'hFF);
    chk("rst_cathode", cathode, 7'h7F);
    chk("rst_dp", dp, 1);
    chk("rst_fd", frame_done, 0);
    rst = 1'b0;

    // Load during the first (dark) frame, visible from the next one.
    skip(5);
    chk("dark_first", anode, 8'hFF);
    pulse_load(32'h12345678, 8'hFF, 8'h00);
    wait_fd();
    skip(2);
    chk("t2_an0", anode, 8'hFE);
    chk("t2_cat0", cathode, 7'b0000000);
    skip(7 * T);
    chk("t2_an7", anode, 8'h7F);
    chk("t2_cat7", cathode, 7'b1111001);
    chk("t2_dp7", dp, 1);

    // Mid-frame load does not disturb the frame in progress.
    wait_fd();
    skip(2);
    pulse_load(32'hDEADBEEF, 8'hFF, 8'h00);
    skip(3 * T - 1);
    chk("t3_an3", anode, 8'hF7);
    chk("t3_cat3", cathode, 7'b0010010);
    wait_fd();
    skip(2);
    chk("t3_catF", cathode, 7'b0001110);
    pulse_load(32'h0000000A, 8'hFF, 8'h00);
    pulse_load(32'h0000000B, 8'hFF, 8'h00);
    wait_fd();
    skip(2);
    chk("t3_last_wins", cathode, 7'b0000011);

    // Blanked upper digits, lit decimal points on lower digits.
    pulse_load(32'hFFFF0000, 8'h0F, 8'hFF);
    wait_fd();
    skip(2);
    chk("t4_an0", anode, 8'hFE);
    chk("t4_cat0", cathode, 7'b1000000);
    chk("t4_dp0", dp, 0);
    skip(4 * T);
    chk("t4_an4", anode, 8'hFF);
    chk("t4_cat4", cathode, 7'h7F);
    chk("t4_dp4", dp, 1);

    // Load exactly on the boundary edge overrides an older pending load.
    wait_fd();
    skip(2);
    pulse_load(32'h00000003, 8'hFF, 8'h00);
    skip(FRAME - 4);
    value = 32'h00000007;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("t5_fd", frame_done, 1);
    @(negedge clk);
    chk("t5_an0", anode, 8'hFE);
    chk("t5_cat0", cathode, 7'b1111000);

    // Reset mid-frame with a pending load: dark and the load is dropped.
    wait_fd();
    skip(2 + 5 * T);
    pulse_load(32'h11111111, 8'hFF, 8'hFF);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_an", anode, 8'hFF);
    chk("t6_cat", cathode, 7'h7F);
    chk("t6_fd", frame_done, 0);
    wait_fd();
    skip(2);
    chk("t6_dark", anode, 8'hFF);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      value = $urandom;
      digit_en = 8'($urandom);
      dp_en = 8'($urandom);
      load = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    load = 1'b0;
    rst = 1'b0;
    skip(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
